// File: rtl/flash_arbiter.sv
// Two-requester SPI mode-0 serial flash reader; port 0 has fixed priority over port 1.
// Optional macro FLASH_FAST_READ_EN: FAST READ (0x0B) plus 8 dummy clocks, SCK_HALF default 2.
module flash_arbiter #(
`ifdef FLASH_FAST_READ_EN
    parameter int SCK_HALF = 2,
`else
    parameter int SCK_HALF = 3,
`endif
    parameter int CS_HIGH  = 8
) (
    input  logic        clk168,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [23:0] addr0,
    input  logic [15:0] len0,
    output logic        gnt0,
    output logic        valid0,
    output logic        done0,
    input  logic        req1,
    input  logic [23:0] addr1,
    input  logic [15:0] len1,
    output logic        gnt1,
    output logic        valid1,
    output logic        done1,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif
    localparam int CMAX = (SCK_HALF > CS_HIGH) ? SCK_HALF : CS_HIGH;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SCK_LAST = CW'(SCK_HALF - 1);
    localparam logic [CW-1:0] CSH_LAST = CW'(CS_HIGH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_FIN, S_REC, S_ZLEN
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_bcnt;
    logic [31:0]    r_tx;
    logic [6:0]     r_rx;
    logic [15:0]    r_left;
    logic           r_port;
    logic           r_abort;
    logic           r_samp;
    logic           r_miso;
    logic           r_gnt0, r_gnt1, r_valid0, r_valid1, r_done0, r_done1;
    logic [7:0]     r_rdata;
    logic           r_busy, r_cs_n, r_sck, r_mosi;

    logic [23:0]    w_addr_sel;
    logic [15:0]    w_len_sel;
    logic           w_req_own;

    assign w_addr_sel = req0 ? addr0 : addr1;
    assign w_len_sel  = req0 ? len0 : len1;
    assign w_req_own  = r_port ? req1 : req0;

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign valid0     = r_valid0;
    assign valid1     = r_valid1;
    assign done0      = r_done0;
    assign done1      = r_done1;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign flash_cs_n = r_cs_n;
    assign flash_sck  = r_sck;
    assign flash_mosi = r_mosi;

    // Single register stage on the flash data line
    always_ff @(posedge clk168 or negedge rst_n) begin
        if (!rst_n) begin
            r_miso <= 1'b0;
        end else begin
            r_miso <= flash_miso;
        end
    end

    // Arbitration, SPI sequencing and byte assembly
    always_ff @(posedge clk168 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bcnt   <= 5'd0;
            r_tx     <= 32'd0;
            r_rx     <= 7'd0;
            r_left   <= 16'd0;
            r_port   <= 1'b0;
            r_abort  <= 1'b0;
            r_samp   <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata  <= 8'd0;
            r_busy   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
        end else begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            r_samp   <= 1'b0;
            if ((r_gnt0 || r_gnt1) && !w_req_own) begin
                r_abort <= 1'b1;
            end
            // r_samp marks the cycle after an SCK rise in DATA; r_miso then holds that bit
            if (r_samp) begin
                r_rx <= {r_rx[5:0], r_miso};
                if (r_bcnt[2:0] == 3'd7) begin
                    r_rdata  <= {r_rx, r_miso};
                    r_valid0 <= ~r_port;
                    r_valid1 <= r_port;
                    r_left   <= r_left - 16'd1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_bcnt  <= 5'd0;
                    r_abort <= 1'b0;
                    if (req0 || req1) begin
                        r_port <= ~req0;
                        r_gnt0 <= req0;
                        r_gnt1 <= ~req0;
                        r_busy <= 1'b1;
                        r_tx   <= {READ_CMD, w_addr_sel};
                        r_left <= w_len_sel;
                        if (w_len_sel == 16'd0) begin
                            r_state <= S_ZLEN;
                        end else begin
                            r_state <= S_CMD;
                            r_cs_n  <= 1'b0;
                            r_mosi  <= READ_CMD[7];
                        end
                    end
                end
                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    if (r_cnt == SCK_LAST) begin
                        r_cnt <= '0;
                        if (!r_sck) begin
                            r_sck  <= 1'b1;
                            r_samp <= (r_state == S_DATA);
                        end else begin
                            // Falling edge: advance MOSI (zeros once the header is out)
                            r_sck  <= 1'b0;
                            r_bcnt <= r_bcnt + 5'd1;
                            r_tx   <= {r_tx[30:0], 1'b0};
                            r_mosi <= r_tx[30];
                            case (r_state)
                                S_CMD: begin
                                    if (r_bcnt == 5'd7) begin
                                        r_state <= S_ADDR;
                                        r_bcnt  <= 5'd0;
                                    end
                                end
                                S_ADDR: begin
                                    if (r_bcnt == 5'd23) begin
`ifdef FLASH_FAST_READ_EN
                                        r_state <= S_DUMMY;
`else
                                        r_state <= S_DATA;
`endif
                                        r_bcnt  <= 5'd0;
                                    end
                                end
                                S_DUMMY: begin
                                    if (r_bcnt == 5'd7) begin
                                        r_state <= S_DATA;
                                        r_bcnt  <= 5'd0;
                                    end
                                end
                                default: begin
                                    if (r_bcnt[2:0] == 3'd7) begin
                                        r_bcnt <= 5'd0;
                                        if ((r_left == 16'd0) || r_abort) begin
                                            r_state <= S_FIN;
                                        end
                                    end
                                end
                            endcase
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    if (r_cnt == SCK_LAST) begin
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b1;
                        r_done0 <= ~r_port;
                        r_done1 <= r_port;
                        r_state <= S_REC;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_REC: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_mosi  <= 1'b0;
                    if (r_cnt == CSH_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ZLEN: begin
                    if (!(r_done0 || r_done1)) begin
                        r_done0 <= ~r_port;
                        r_done1 <= r_port;
                    end else begin
                        r_done0 <= 1'b0;
                        r_done1 <= 1'b0;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the configuration serial flash (SPI mode 0) between two requesters: port 0 is the power-up ROM-to-RAM loader and port 1 is a runtime reader (magic/service ROM fetch).
- Issues the READ command, the 24-bit address and a byte burst, then streams bytes back to the granted requester.
- Sits between the memory initializer and the flash pins and replaces direct flash access from clk7. Runs from clk168.

Parameters:
- SCK_HALF, default 3: clk168 cycles per SCK half-period. Minimum 2. Default gives 28 MHz SCK.
- CS_HIGH, default 8: minimum clk168 cycles flash_cs_n stays high between transactions.

Ports:
- clk168  in  1  system clock, 168 MHz
- rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 transaction request, level, held until done0
- addr0  in  24  requester 0 start byte address, sampled at grant
- len0  in  16  requester 0 byte count, sampled at grant
- gnt0  out  1  requester 0 owns the flash
- valid0  out  1  one-cycle strobe: rdata holds a byte for requester 0
- done0  out  1  one-cycle strobe: requester 0 transaction finished
- req1, addr1, len1, gnt1, valid1, done1: same as port 0, for requester 1
- rdata  out  8  shared read data, valid only while the matching validN is high
- busy  out  1  transaction in progress, including CS_HIGH recovery
- flash_cs_n  out  1  flash chip select
- flash_sck  out  1  flash clock
- flash_mosi  out  1  flash serial input
- flash_miso  in  1  flash serial output

Behaviour:
- Reset values: flash_cs_n=1, flash_sck=0, flash_mosi=0, all gnt/valid/done/busy=0, rdata=0, state IDLE.
- Arbitration happens only in IDLE with fixed priority: req0 wins over req1. The grant is registered, so gntN rises one cycle after reqN is seen. Latch addrN and lenN on that same edge. The grant holds until doneN.
- States: IDLE -> CMD (8 bits, 0x03) -> ADDR (24 bits, MSB first) -> [DUMMY] -> DATA (lenN bytes) -> RECOVER (CS_HIGH cycles) -> IDLE.
- flash_cs_n falls on the cycle the FSM enters CMD. The first MOSI bit must be valid at least SCK_HALF cycles before the first SCK rise.
- SCK is generated by a half-period counter. MOSI changes only while SCK is low (after the falling edge). MISO is sampled on the clk168 cycle in which SCK rises.
- flash_miso passes through a single register stage before sampling. Sampling is therefore aligned to the SCK rise, plus one cycle.
- Data shift is MSB first. After the 8th sampled bit of each byte, rdata is updated and validN pulses for exactly one cycle.
- Consecutive bytes are streamed without deasserting CS. Byte spacing is 16*SCK_HALF cycles (48 at default).
- After the last byte: SCK ends low, then flash_cs_n rises and doneN pulses on the same cycle. gntN drops the next cycle, then RECOVER runs.
- busy=1 from grant until RECOVER expires.
- len=0: grant, then doneN one cycle later. No CS activity and no RECOVER.
- len is 16-bit unsigned, so the maximum is 65535 bytes. Address wrap past 0xFFFFFF is left to the flash; the internal address is never incremented.
- Abort: if reqN falls while granted, finish the current byte, deliver it with validN, then terminate as a normal end with doneN and RECOVER.
- If both requests are asserted in IDLE, port 0 is served. Port 1 starts after port 0's RECOVER, provided req0 is then low.
- Asynchronous reset mid-transaction returns everything to reset values immediately: CS goes high and no done is issued.

Optional Feature:
- FLASH_FAST_READ_EN.
- Defined: CMD sends 0x0B and a DUMMY state of 8 SCK cycles (MOSI=0, MISO ignored) follows ADDR. SCK_HALF default becomes 2 (42 MHz SCK).
- Undefined: CMD sends 0x03, there is no DUMMY state, and SCK_HALF defaults to 3.

Test Plan:
- Single read: req0, addr0=0x013256, len0=4, flash model bytes AA 55 01 FE -> MOSI carries 03 01 32 56; four valid0 strobes with rdata AA,55,01,FE, 48 cycles apart; done0 then cs_n high; busy low CS_HIGH cycles later.
- Contention: req0 and req1 asserted the same cycle (len 2 each) -> gnt0 first; gnt1 only after RECOVER; valid1 never pulses during gnt0.
- Zero length: req1, len1=0 -> gnt1, done1 one cycle later, flash_cs_n stays 1 throughout.
- Abort: req0 with len0=100, drop req0 mid-byte 5 -> byte 5 delivered, 5 valid0 pulses total, done0, cs_n high.
- Reset mid-DATA: pulse rst_n low during byte 2 -> cs_n=1, sck=0, gnt0=0 immediately, no done0; a new request after reset completes correctly.
- FLASH_FAST_READ_EN defined: same as the single-read scenario -> MOSI carries 0B 01 32 56 then 8 dummy clocks; data identical; SCK half-period 2 cycles.
